// File: rtl/digit_serial_alu.sv
// digit_serial_alu: digit-serial adder/subtractor.
// Operands are consumed DIGIT bits per clock, least significant digit first,
// through one DIGIT-bit ripple slice and a carry flop. The result and flags
// are registered on completion and held until the next completion.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start, ready=1
// S_RUN  | processing digits, counter runs 0..N-1, ready=0
// S_DONE | result registers just updated, done=1, ready=1 (can restart)
module digit_serial_alu #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             ci,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             co,
    output logic             v,
    output logic             eq,
    output logic             ltu,
    output logic             lts
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (!(DIGIT == 1 || DIGIT == 2 || DIGIT == 4) || WIDTH < DIGIT || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("digit_serial_alu: DIGIT must be 1, 2 or 4 and WIDTH a nonzero multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic             zacc;
    logic             zero_next;
    logic             accept;
    logic             last_digit;

    logic [DIGIT:0]   slice;
    logic [DIGIT-1:0] sum_d;
    logic             cout;
    logic             cin_msb;

    assign accept     = start & ready;
    assign last_digit = (cnt == LAST);

    // One DIGIT-bit ripple slice; the carry into its top bit is recovered
    // from the sum bit so no separate partial adder is needed for V.
    assign slice     = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    assign sum_d     = slice[DIGIT-1:0];
    assign cout      = slice[DIGIT];
    assign cin_msb   = sum_d[DIGIT-1] ^ opa[DIGIT-1] ^ opb[DIGIT-1];
    assign zero_next = zacc | (|sum_d);

    generate
        if (WIDTH > DIGIT) begin : g_shift
            assign acc_next = {sum_d, acc[WIDTH-1:DIGIT]};
        end else begin : g_single
            assign acc_next = sum_d;
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last_digit) state_next = S_DONE;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state only
    always_comb begin
        ready = 1'b1;
        done  = 1'b0;
        case (state)
            S_RUN:   ready = 1'b0;
            S_DONE:  done  = 1'b1;
            default: ;
        endcase
    end

    // Operand shift registers, carry flop, working register and digit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            zacc  <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            opa   <= a;
            opb   <= b ^ {WIDTH{sub}};
            carry <= ci ^ sub;
            zacc  <= 1'b0;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            opa   <= opa >> DIGIT;
            opb   <= opb >> DIGIT;
            acc   <= acc_next;
            carry <= cout;
            zacc  <= zero_next;
            cnt   <= cnt + CW'(1);
        end
    end

    // Result registers load on the edge that processes the last digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y  <= '0;
            co <= 1'b0;
            v  <= 1'b0;
            eq <= 1'b0;
        end else if (state == S_RUN && last_digit) begin
            y  <= acc_next;
            co <= cout;
            v  <= cin_msb ^ cout;
            eq <= ~zero_next;
        end
    end

    assign ltu = ~co;
    assign lts = y[WIDTH-1] ^ v;

endmodule

// File: tb/tb_digit_serial_alu.sv
// Bench for digit_serial_alu: three instances (32/4, 8/1, 32/2) checked
// against literal expectations and an integer reference adder.
module tb_digit_serial_alu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance 0: WIDTH=32 DIGIT=4
    logic s0_start = 0, s0_sub = 0, s0_ci = 0;
    logic [31:0] s0_a = 0, s0_b = 0;
    logic r0_ready, r0_done, r0_co, r0_v, r0_eq, r0_ltu, r0_lts;
    logic [31:0] r0_y;
    // instance 1: WIDTH=8 DIGIT=1
    logic s1_start = 0, s1_sub = 0, s1_ci = 0;
    logic [7:0] s1_a = 0, s1_b = 0;
    logic r1_ready, r1_done, r1_co, r1_v, r1_eq, r1_ltu, r1_lts;
    logic [7:0] r1_y;
    // instance 2: WIDTH=32 DIGIT=2
    logic s2_start = 0, s2_sub = 0, s2_ci = 0;
    logic [31:0] s2_a = 0, s2_b = 0;
    logic r2_ready, r2_done, r2_co, r2_v, r2_eq, r2_ltu, r2_lts;
    logic [31:0] r2_y;

    digit_serial_alu #(.WIDTH(32), .DIGIT(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(s0_start), .sub(s0_sub), .ci(s0_ci),
        .a(s0_a), .b(s0_b), .ready(r0_ready), .done(r0_done), .y(r0_y),
        .co(r0_co), .v(r0_v), .eq(r0_eq), .ltu(r0_ltu), .lts(r0_lts));

    digit_serial_alu #(.WIDTH(8), .DIGIT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .sub(s1_sub), .ci(s1_ci),
        .a(s1_a), .b(s1_b), .ready(r1_ready), .done(r1_done), .y(r1_y),
        .co(r1_co), .v(r1_v), .eq(r1_eq), .ltu(r1_ltu), .lts(r1_lts));

    digit_serial_alu #(.WIDTH(32), .DIGIT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(s2_start), .sub(s2_sub), .ci(s2_ci),
        .a(s2_a), .b(s2_b), .ready(r2_ready), .done(r2_done), .y(r2_y),
        .co(r2_co), .v(r2_v), .eq(r2_eq), .ltu(r2_ltu), .lts(r2_lts));

    typedef struct packed {
        logic [31:0] y;
        logic co;
        logic v;
        logic eq;
        logic ltu;
        logic lts;
    } res_t;

    localparam res_t RES_RESET = '{y: 32'd0, co: 1'b0, v: 1'b0, eq: 1'b0, ltu: 1'b1, lts: 1'b0};

    res_t sb_q[$];
    int checks = 0;
    int failures = 0;

    function automatic res_t get_out(int sel);
        res_t r;
        case (sel)
            0: r = '{y: r0_y, co: r0_co, v: r0_v, eq: r0_eq, ltu: r0_ltu, lts: r0_lts};
            1: r = '{y: {24'd0, r1_y}, co: r1_co, v: r1_v, eq: r1_eq, ltu: r1_ltu, lts: r1_lts};
            default: r = '{y: r2_y, co: r2_co, v: r2_v, eq: r2_eq, ltu: r2_ltu, lts: r2_lts};
        endcase
        return r;
    endfunction

    function automatic logic done_of(int sel);
        case (sel)
            0: return r0_done;
            1: return r1_done;
            default: return r2_done;
        endcase
    endfunction

    function automatic logic ready_of(int sel);
        case (sel)
            0: return r0_ready;
            1: return r1_ready;
            default: return r2_ready;
        endcase
    endfunction

    function automatic string fmt(res_t r);
        return $sformatf("y=%h co=%b v=%b eq=%b ltu=%b lts=%b", r.y, r.co, r.v, r.eq, r.ltu, r.lts);
    endfunction

    // Whole-word reference: add with optional inverted B, sign-rule overflow
    function automatic res_t model(int w, logic [31:0] a, logic [31:0] b, logic sub, logic ci);
        logic [63:0] mask, av, bb, full;
        res_t r;
        mask = (64'd1 << w) - 64'd1;
        av   = {32'd0, a} & mask;
        bb   = (sub ? ~{32'd0, b} : {32'd0, b}) & mask;
        full = av + bb + {63'd0, ci ^ sub};
        r.y   = full[31:0] & mask[31:0];
        r.co  = full[w];
        r.v   = (av[w-1] == bb[w-1]) && (r.y[w-1] != av[w-1]);
        r.eq  = (r.y == 32'd0);
        r.ltu = ~r.co;
        r.lts = r.y[w-1] ^ r.v;
        return r;
    endfunction

    // Drive one start pulse; returns #1 after the accepting edge
    task automatic launch(int sel, logic [31:0] a, logic [31:0] b, logic sub, logic ci);
        @(negedge clk);
        case (sel)
            0: begin s0_a = a; s0_b = b; s0_sub = sub; s0_ci = ci; s0_start = 1; end
            1: begin s1_a = a[7:0]; s1_b = b[7:0]; s1_sub = sub; s1_ci = ci; s1_start = 1; end
            default: begin s2_a = a; s2_b = b; s2_sub = sub; s2_ci = ci; s2_start = 1; end
        endcase
        @(posedge clk);
        #1;
        s0_start = 0;
        s1_start = 0;
        s2_start = 0;
    endtask

    task automatic wait_done(int sel, int limit, output int cyc, output bit ok);
        cyc = 0;
        ok = 0;
        while (cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done_of(sel)) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s0_a = $urandom; s0_b = $urandom; s0_sub = 1'($urandom); s0_ci = 1'($urandom); s0_start = 1;
            s1_a = 8'($urandom); s1_b = 8'($urandom); s1_sub = 1'($urandom); s1_ci = 1'($urandom); s1_start = 1;
            s2_a = $urandom; s2_b = $urandom; s2_sub = 1'($urandom); s2_ci = 1'($urandom); s2_start = 1;
        end
        @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            res_t obs;
            obs = get_out(s);
            checks++;
            if (ready_of(s) !== 1'b1 || done_of(s) !== 1'b0) begin
                failures++;
                $display("FAIL reset_handshake[%0d]: got ready=%b done=%b, want ready=1 done=0", s, ready_of(s), done_of(s));
            end
            checks++;
            if (obs !== RES_RESET) begin
                failures++;
                $display("FAIL reset_outputs[%0d]: got %s, want %s", s, fmt(obs), fmt(RES_RESET));
            end
        end
        @(negedge clk);
        s0_start = 0; s1_start = 0; s2_start = 0;
        rst_n = 1;
    endtask

    task automatic test_add_wrap();
        int cyc;
        bit ok;
        res_t exp, obs;
        sb_q.push_back('{y: 32'h0, co: 1'b1, v: 1'b0, eq: 1'b1, ltu: 1'b0, lts: 1'b0});
        launch(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        wait_done(0, 30, cyc, ok);
        exp = sb_q.pop_front();
        obs = get_out(0);
        checks++;
        if (!ok || cyc + 1 != 9) begin
            failures++;
            $display("FAIL add_wrap_latency: got %0d cycles (done seen=%0b), want 9", cyc + 1, ok);
        end
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL add_wrap_result: got %s, want %s", fmt(obs), fmt(exp));
        end
    endtask

    task automatic test_sub_compare();
        logic [31:0] ta [2];
        logic [31:0] tb [2];
        res_t te [2];
        ta[0] = 32'd5;          tb[0] = 32'd7;
        te[0] = '{y: 32'hFFFF_FFFE, co: 1'b0, v: 1'b0, eq: 1'b0, ltu: 1'b1, lts: 1'b1};
        ta[1] = 32'h8000_0000;  tb[1] = 32'd1;
        te[1] = '{y: 32'h7FFF_FFFF, co: 1'b1, v: 1'b1, eq: 1'b0, ltu: 1'b0, lts: 1'b1};
        for (int i = 0; i < 2; i++) begin
            int cyc;
            bit ok;
            res_t exp, obs;
            sb_q.push_back(te[i]);
            launch(0, ta[i], tb[i], 1'b1, 1'b0);
            wait_done(0, 30, cyc, ok);
            exp = sb_q.pop_front();
            obs = get_out(0);
            checks++;
            if (!ok || obs !== exp) begin
                failures++;
                $display("FAIL sub_compare[%0d]: got %s (done seen=%0b), want %s", i, fmt(obs), ok, fmt(exp));
            end
        end
    endtask

    task automatic test_handshake();
        logic [31:0] prev_y;
        int lat;
        int cyc;
        bit ok;
        bit seen;
        res_t exp, obs;
        prev_y = r0_y;
        sb_q.push_back('{y: 32'h30, co: 1'b0, v: 1'b0, eq: 1'b0, ltu: 1'b1, lts: 1'b0});
        @(negedge clk);
        s0_a = 32'h10; s0_b = 32'h20; s0_sub = 0; s0_ci = 0; s0_start = 1;
        @(posedge clk);
        #1;
        lat = 1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            s0_a = $urandom; s0_b = $urandom; s0_sub = 1'($urandom); s0_ci = 1'($urandom);
            @(posedge clk);
            #1;
            lat++;
            if (r0_done) begin
                seen = 1;
                break;
            end
            checks++;
            if (r0_y !== prev_y || r0_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_during_run: got y=%h ready=%b, want y=%h ready=0", r0_y, r0_ready, prev_y);
            end
        end
        checks++;
        if (!seen || lat != 9) begin
            failures++;
            $display("FAIL start_during_run_latency: got %0d cycles (done seen=%0b), want 9", lat, seen);
        end
        exp = sb_q.pop_front();
        obs = get_out(0);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL start_during_run_result: got %s, want %s", fmt(obs), fmt(exp));
        end
        // start still high through the DONE cycle: new operands accepted at once
        s0_a = 32'd3; s0_b = 32'd4; s0_sub = 0; s0_ci = 0;
        sb_q.push_back('{y: 32'd7, co: 1'b0, v: 1'b0, eq: 1'b0, ltu: 1'b1, lts: 1'b0});
        @(posedge clk);
        #1;
        checks++;
        if (r0_ready !== 1'b0 || r0_done !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back_accept: got ready=%b done=%b, want ready=0 done=0", r0_ready, r0_done);
        end
        @(negedge clk);
        s0_start = 0;
        wait_done(0, 30, cyc, ok);
        exp = sb_q.pop_front();
        obs = get_out(0);
        checks++;
        if (!ok || cyc + 1 != 9) begin
            failures++;
            $display("FAIL back_to_back_latency: got %0d cycles (done seen=%0b), want 9", cyc + 1, ok);
        end
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL back_to_back_result: got %s, want %s", fmt(obs), fmt(exp));
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit ok;
        bit stray;
        res_t exp, obs;
        launch(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        obs = get_out(0);
        checks++;
        if (obs !== RES_RESET || r0_done !== 1'b0 || r0_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_outputs: got %s done=%b ready=%b, want %s done=0 ready=1", fmt(obs), r0_done, r0_ready, fmt(RES_RESET));
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        stray = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (r0_done) stray = 1;
        end
        checks++;
        if (stray || r0_y !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset_abort: got stray done=%0b y=%h, want no done y=00000000", stray, r0_y);
        end
        sb_q.push_back('{y: 32'h2345_6789, co: 1'b0, v: 1'b0, eq: 1'b0, ltu: 1'b1, lts: 1'b0});
        launch(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        wait_done(0, 30, cyc, ok);
        exp = sb_q.pop_front();
        obs = get_out(0);
        checks++;
        if (!ok || obs !== exp) begin
            failures++;
            $display("FAIL mid_reset_rerun: got %s (done seen=%0b), want %s", fmt(obs), ok, fmt(exp));
        end
    endtask

    task automatic test_width8();
        int cyc;
        bit ok;
        res_t exp, obs;
        sb_q.push_back('{y: 32'h80, co: 1'b0, v: 1'b1, eq: 1'b0, ltu: 1'b1, lts: 1'b0});
        launch(1, 32'h7F, 32'h01, 1'b0, 1'b0);
        wait_done(1, 30, cyc, ok);
        exp = sb_q.pop_front();
        obs = get_out(1);
        checks++;
        if (!ok || cyc + 1 != 9) begin
            failures++;
            $display("FAIL w8_latency: got %0d cycles (done seen=%0b), want 9", cyc + 1, ok);
        end
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL w8_result: got %s, want %s", fmt(obs), fmt(exp));
        end
    endtask

    task automatic test_random(int sel, int w, int lat_exp, int count);
        int bad;
        bad = 0;
        for (int i = 0; i < count; i++) begin
            logic [31:0] ra, rb;
            logic rs, rc;
            int cyc;
            bit ok;
            res_t exp, obs;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = ra;
                1: ra = 32'd0;
                2: begin ra = 32'hFFFF_FFFF; rb = 32'hFFFF_FFFF; end
                default: ;
            endcase
            if (w < 32) begin
                ra = ra & ((32'd1 << w) - 32'd1);
                rb = rb & ((32'd1 << w) - 32'd1);
            end
            rs = 1'($urandom);
            rc = 1'($urandom);
            sb_q.push_back(model(w, ra, rb, rs, rc));
            launch(sel, ra, rb, rs, rc);
            wait_done(sel, 40, cyc, ok);
            exp = sb_q.pop_front();
            obs = get_out(sel);
            checks++;
            if (!ok || cyc + 1 != lat_exp) begin
                failures++;
                if (bad < 5) $display("FAIL rand_latency[%0d] op %0d: got %0d cycles (done seen=%0b), want %0d", sel, i, cyc + 1, ok, lat_exp);
                bad++;
            end
            checks++;
            if (obs !== exp) begin
                failures++;
                if (bad < 5) $display("FAIL rand_result[%0d] op %0d a=%h b=%h sub=%b ci=%b: got %s, want %s", sel, i, ra, rb, rs, rc, fmt(obs), fmt(exp));
                bad++;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_wrap();
        test_sub_compare();
        test_handshake();
        test_reset_mid();
        test_width8();
        test_random(0, 32, 9, 1000);
        test_random(1, 8, 9, 1000);
        test_random(2, 32, 17, 1000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/digit_serial_alu.md
# digit_serial_alu

Parametrised digit-serial adder/subtractor for the bit-serial datapath. It consumes two WIDTH-bit operands DIGIT bits per clock, least significant digit first, using one DIGIT-bit ripple slice plus a carry flop in place of a full-width adder chain. It returns a registered result with carry, overflow, equality and compare flags. It sits beside the register file as the low-gate-count arithmetic unit for the discrete 74-series build and generalises the single-cycle ripple $alu mapping to a configurable width and digit size.

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT and ≥ DIGIT.
- DIGIT, 4, bits processed per cycle; legal values 1, 2, 4 (4 matches one nibble adder slice). An illegal value or a WIDTH not divisible by DIGIT is an elaboration error.
- CLK  input  1  clock; all state changes on the rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- START  input  1  request; accepted only when READY=1.
- SUB  input  1  0: A+B+CI; 1: A+~B+~CI (CI=0 gives A−B).
- CI  input  1  carry/borrow-in, sampled with START.
- A  input  WIDTH  operand A, sampled on accept.
- B  input  WIDTH  operand B, sampled on accept.
- READY  output  1  unit can accept START (state IDLE or DONE).
- DONE  output  1  one-cycle pulse: result registers just updated.
- Y  output  WIDTH  result, held until the next completion.
- CO  output  1  carry out of the MSB (for SUB: 1 = no borrow).
- V  output  1  signed overflow (carry into MSB XOR carry out of MSB).
- EQ  output  1  Y == 0.
- LTU  output  1  unsigned A<B; meaningful after SUB; equals ~CO.
- LTS  output  1  signed A<B; meaningful after SUB; equals Y[WIDTH-1] XOR V.

## Operation
- N = WIDTH/DIGIT digit cycles. Digit counter width is clog2(N), minimum 1.
- States:
  - IDLE: READY=1.
  - RUN: READY=0; digit counter runs 0..N−1.
  - DONE: READY=1; DONE=1.
- Transitions:
  - IDLE → RUN on START.
  - RUN → DONE when the counter reaches N−1.
  - DONE → RUN on START, otherwise → IDLE.
- Accept (START & READY):
  - A and B are copied into operand shift registers; B is inverted when SUB=1.
  - The carry flop loads CI XOR SUB.
  - The zero accumulator clears and the counter clears.
- Each RUN cycle:
  - The low DIGIT bits of both shift registers feed the ripple slice together with the carry flop.
  - The sum digit shifts into the top of the working register, and both operand registers shift right by DIGIT.
  - The carry flop takes the slice carry-out.
  - The zero accumulator ORs in the sum digit.
  - On the last digit, the carry into bit DIGIT−1 of the slice is also captured for V.
- Completion (RUN → DONE edge): the working register, carry, overflow and zero flag are copied to Y, CO, V and EQ. LTU and LTS are combinational from these registered values.
- START while READY=0 is ignored, with no side effect.
- A, B, SUB and CI are don't-care outside the accept cycle.
- Y and all flags keep their previous values during RUN; only the completion edge updates them.
- Reset, whenever asserted and including mid-RUN:
  - State returns to IDLE and the counter and working registers clear.
  - Y=0, CO=0, V=0, EQ=0, DONE=0, READY=1.
  - LTU=1 and LTS=0 follow from the combinational definitions.
  - An aborted operation produces no DONE. Normal operation resumes on the first edge after nRST deasserts.

## Timing
- Accept at edge E0. Digit i is processed at edge E(i+1) for i = 0..N−1.
- DONE is high and Y/flags are valid in the cycle after E(N). Latency is N+1 cycles from the START cycle to the DONE cycle; defaults give 9.
- Back-to-back: START held high during DONE is accepted at that edge, giving a throughput of one result per N+1 cycles.
- READY is registered-state decoded with no combinational path from START.
- Critical path is one DIGIT-bit ripple plus the carry flop, independent of WIDTH.

## Test plan
- Reset: hold nRST=0 for 3 cycles with random inputs → READY=1, DONE=0, Y=0, CO=0, V=0, EQ=0, LTU=1, LTS=0.
- ADD wrap (defaults): A=0xFFFFFFFF, B=1, SUB=0, CI=0 → DONE exactly 9 cycles after the START cycle; Y=0, CO=1, EQ=1, V=0.
- SUB compare:
  - 5−7 → Y=0xFFFFFFFE, CO=0, LTU=1, LTS=1, EQ=0.
  - 0x80000000−1 → Y=0x7FFFFFFF, CO=1, V=1, LTS=1, LTU=0.
- Handshake: START pulsed every cycle during RUN → no extra DONE, Y unchanged until completion. START held through DONE → second op 3+4 accepted at once, Y=7 after a further 9 cycles.
- Reset mid-operation: nRST=0 after digit 3 of 0x12345678+0x11111111 → no DONE, Y=0. Rerun after release → Y=0x23456789, CO=0.
- Parameter sweep: WIDTH=8, DIGIT=1: 0x7F+0x01 → DONE 9 cycles after START, Y=0x80, V=1, CO=0. Repeat the regression at DIGIT=2 and DIGIT=4 against a reference adder with 1000 random operands each.
